// File: rtl/sum_uart_tx.sv
// Serialises each accepted 8-bit sum as one UART frame: start, 8 data bits LSB first,
// optional even parity, stop. Counts completed frames in frame_cnt.
module sum_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sum_in,
    input  logic       sum_valid,
    output logic       sum_ready,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    typedef struct packed {
        logic [7:0] shift;
        logic       par;
    } frame_t;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    frame_t        fr;

    logic baud_last;
    logic accept;

    assign baud_last = (baud == BAUD_LAST);

    // Ready also in the final stop cycle so a held sum_valid chains frames with no idle gap.
    assign sum_ready = (state == IDLE) || ((state == STOP) && baud_last);
    assign busy      = (state != IDLE);
    assign accept    = sum_valid && sum_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            fr        <= '0;
            tx        <= 1'b1;
            frame_cnt <= '0;
        end else if (accept) begin
            if (state == STOP)
                frame_cnt <= frame_cnt + 8'd1;
            state    <= START;
            baud     <= '0;
            bit_idx  <= '0;
            fr.shift <= sum_in;
            fr.par   <= ^sum_in;
            tx       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    baud <= '0;
                    tx   <= 1'b1;
                end
                START: begin
                    if (baud_last) begin
                        baud  <= '0;
                        state <= DATA;
                        tx    <= fr.shift[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= fr.par;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            fr.shift <= {1'b0, fr.shift[7:1]};
                            tx       <= fr.shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                PARITY: begin
                    if (baud_last) begin
                        baud  <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud      <= '0;
                        state     <= IDLE;
                        frame_cnt <= frame_cnt + 8'd1;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                    tx <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    baud  <= '0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
